spike_time_encoder: RTL and testbench

Temporal (race-logic) encoder on the transmit side of the pulse-based spike interface that feeds the k-winner-take-all stage. It accepts one vector of per-channel values per gamma cycle over a valid/ready handshake. In the following gamma cycle it emits, per enabled channel, one PULSE_WIDTH-cycle pulse whose onset time encodes the value. Output vector format and pulse shape match what kwta consumes on `input_spikes`.

---
 rtl/tnn_pkg.sv | 23 ++
 rtl/gamma_counter.sv | 33 +++
 rtl/spike_time_encoder.sv | 99 +++++++++
 tb/tb_spike_time_encoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared helpers for the temporal (race-logic) spike path.
// Build option: SPIKE_ENCODER_INVERT_EN selects the intensity-to-latency
// onset mapping (larger values spike earlier).
package tnn_pkg;

  // Width that holds any gamma count plus a pulse width without overflow.
  function automatic int unsigned gamma_count_width(input int unsigned gamma_cycle_width);
    return $clog2(gamma_cycle_width) + 1;
  endfunction

  // Onset time within a gamma cycle for a channel value.
  function automatic int unsigned onset_time(input int unsigned value,
                                             input int unsigned value_width);
    int unsigned max_value;
    max_value = (32'd1 << value_width) - 32'd1;
`ifdef SPIKE_ENCODER_INVERT_EN
    return max_value - (value & max_value);
`else
    return value & max_value;
`endif
  endfunction

endpackage

// File: rtl/gamma_counter.sv
// Free-running gamma-cycle counter: 0 .. GAMMA_CYCLE_WIDTH-1, then wraps.
// wrap is high during the last count, so the following edge is the wrap edge.
module gamma_counter
  import tnn_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  localparam int CW = int'(gamma_count_width(GAMMA_CYCLE_WIDTH))
) (
  input  logic          aclk,
  input  logic          grst,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_WIDTH - 1);

  logic [CW-1:0] r_count;

  // Count through the gamma cycle, restarting at zero after the last cycle.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count = r_count;
  assign wrap  = (r_count == LAST);

endmodule

// File: rtl/spike_time_encoder.sv
// Race-logic encoder: one sample per gamma cycle in, one pulse per enabled
// channel out in the following gamma cycle, onset time = encoded value.
// Build option: SPIKE_ENCODER_INVERT_EN (inverted onset mapping, see tnn_pkg).
module spike_time_encoder
  import tnn_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_INPUTS        = 16,
  parameter int VALUE_WIDTH       = 3
) (
  input  logic                              aclk,
  input  logic                              grst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] in_values,
  input  logic [NUM_INPUTS-1:0]             in_enable,
  output logic                              gamma_start,
  output logic [NUM_INPUTS-1:0]             output_spikes
);

  localparam int CW = int'(gamma_count_width(GAMMA_CYCLE_WIDTH));

  // A pulse starting at the latest onset must still end inside the gamma cycle.
  if (((2 ** VALUE_WIDTH) - 1) + PULSE_WIDTH > GAMMA_CYCLE_WIDTH) begin : g_param_check
    $error("spike_time_encoder: max onset + PULSE_WIDTH exceeds GAMMA_CYCLE_WIDTH");
  end

  logic [CW-1:0]                       w_count;
  logic                                w_wrap;
  logic                                w_xfer;

  logic                                r_pending_full;
  logic [NUM_INPUTS*VALUE_WIDTH-1:0]   r_pending_values;
  logic [NUM_INPUTS-1:0]               r_pending_en;
  logic [NUM_INPUTS*VALUE_WIDTH-1:0]   r_active_values;
  logic [NUM_INPUTS-1:0]               r_active_en;

  gamma_counter #(
    .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
  ) u_gamma_counter (
    .aclk (aclk),
    .grst (grst),
    .count(w_count),
    .wrap (w_wrap)
  );

  assign in_ready    = ~r_pending_full;
  assign w_xfer      = in_valid & ~r_pending_full;
  assign gamma_start = (w_count == '0);

  // Handshake state and active enables: pending promotes to active on the wrap
  // edge, an empty pending lets a wrap-edge transfer bypass straight to active,
  // and otherwise the new gamma cycle is silent.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      r_pending_full <= 1'b0;
      r_active_en    <= '0;
    end else if (w_wrap) begin
      if (r_pending_full) begin
        r_active_en    <= r_pending_en;
        r_pending_full <= 1'b0;
      end else if (w_xfer) begin
        r_active_en <= in_enable;
      end else begin
        r_active_en <= '0;
      end
    end else if (w_xfer) begin
      r_pending_full <= 1'b1;
    end
  end

  // Sample payload, captured only on the transfer / promotion edges.
  // NOTE: no reset here on purpose; these registers are only observed through
  // r_pending_full or r_active_en, which are reset, so clearing them adds nothing.
  always_ff @(posedge aclk) begin
    if (w_wrap) begin
      if (r_pending_full) begin
        r_active_values <= r_pending_values;
      end else if (w_xfer) begin
        r_active_values <= in_values;
      end
    end else if (w_xfer) begin
      r_pending_values <= in_values;
      r_pending_en     <= in_enable;
    end
  end

  // Per-channel pulse window decoded from registered state only.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    logic [CW-1:0] w_onset;
    assign w_onset = CW'(onset_time(32'(r_active_values[i*VALUE_WIDTH +: VALUE_WIDTH]),
                                    VALUE_WIDTH));
    assign output_spikes[i] = r_active_en[i] &&
                              (w_count >= w_onset) &&
                              (w_count < w_onset + CW'(PULSE_WIDTH));
  end

endmodule

// File: tb/tb_spike_time_encoder.sv
// Self-checking bench for spike_time_encoder: table-driven vectors,
// hand-written corner sequences and randomized traffic against a
// schedule-based reference model.
module tb_spike_time_encoder;

  localparam int GCW = 16;
  localparam int PW  = 8;
  localparam int NI  = 16;
  localparam int VW  = 3;

  logic             aclk = 1'b0;
  logic             grst = 1'b1;
  logic             in_valid = 1'b0;
  logic [NI*VW-1:0] in_values = '0;
  logic [NI-1:0]    in_enable = '0;
  logic             in_ready;
  logic             gamma_start;
  logic [NI-1:0]    output_spikes;

  spike_time_encoder #(
    .GAMMA_CYCLE_WIDTH(GCW),
    .PULSE_WIDTH      (PW),
    .NUM_INPUTS       (NI),
    .VALUE_WIDTH      (VW)
  ) dut (
    .aclk         (aclk),
    .grst         (grst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_values    (in_values),
    .in_enable    (in_enable),
    .gamma_start  (gamma_start),
    .output_spikes(output_spikes)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Time t counts clock cycles since reset release; gamma index = t / GCW.
  // Each accepted sample is scheduled into the gamma cycle where it fires.
  typedef struct packed {
    logic [NI*VW-1:0] values;
    logic [NI-1:0]    en;
  } sample_t;

  sample_t sched [int];
  int      t;
  int      checks = 0;
  int      errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic int onset_of(input int v);
`ifdef SPIKE_ENCODER_INVERT_EN
    return ((1 << VW) - 1) - v;
`else
    return v;
`endif
  endfunction

  function automatic int cur_c();
    return t % GCW;
  endfunction

  function automatic logic [NI-1:0] exp_spikes();
    logic [NI-1:0] r;
    sample_t       s;
    int            o;
    r = '0;
    if (sched.exists(t / GCW)) begin
      s = sched[t / GCW];
      for (int i = 0; i < NI; i++) begin
        o = onset_of(int'(s.values[i*VW +: VW]));
        if (s.en[i] && cur_c() >= o && cur_c() < o + PW) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Ready unless a sample is already waiting for the next gamma cycle.
  function automatic logic exp_ready();
    return !sched.exists(t / GCW + 1);
  endfunction

  // Advance one clock with the inputs currently driven, then compare.
  task automatic tick();
    bit xfer;
    int tgt;
    xfer = in_valid && exp_ready();
    if (xfer) begin
      tgt = ((t + 1) % GCW == 0) ? (t + 1) / GCW : (t + 1) / GCW + 1;
      sched[tgt] = '{values: in_values, en: in_enable};
    end
    @(posedge aclk);
    t++;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_ready()));
    check("gamma_start", 32'(gamma_start), 32'(cur_c() == 0));
    check("output_spikes", 32'(output_spikes), 32'(exp_spikes()));
  endtask

  task automatic idle_until(input int c);
    for (int k = 0; k < 2 * GCW && cur_c() != c; k++) tick();
  endtask

  task automatic offer(input logic [NI*VW-1:0] v, input logic [NI-1:0] e);
    in_valid  = 1'b1;
    in_values = v;
    in_enable = e;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge aclk);
    #2;
    grst = 1'b0;
    t = 0;
    sched.delete();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_gamma_start", 32'(gamma_start), 32'd1);
    check("rst_spikes", 32'(output_spikes), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               offer_c;
    logic [NI*VW-1:0] values;
    logic [NI-1:0]    en;
    int               probe_c;
    logic [NI-1:0]    exp_def;
    logic [NI-1:0]    exp_inv;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [NI-1:0] acc;
    int            low_cycles;

    // ch0=3, ch1=7 enabled; probes in the following gamma cycle.
    vecs[0] = '{5, 48'h3B, 16'h0003, 2,  16'h0000, 16'h0002};
    vecs[1] = '{5, 48'h3B, 16'h0003, 3,  16'h0001, 16'h0002};
    vecs[2] = '{5, 48'h3B, 16'h0003, 7,  16'h0003, 16'h0003};
    vecs[3] = '{5, 48'h3B, 16'h0003, 10, 16'h0003, 16'h0001};
    vecs[4] = '{5, 48'h3B, 16'h0003, 11, 16'h0002, 16'h0001};
    vecs[5] = '{5, 48'h3B, 16'h0003, 14, 16'h0002, 16'h0000};
    vecs[6] = '{5, 48'h3B, 16'h0003, 15, 16'h0000, 16'h0000};
    // ch2=5 disabled, ch3=0 enabled.
    vecs[7] = '{5, 48'h140, 16'h0008, 0, 16'h0008, 16'h0000};
    vecs[8] = '{5, 48'h140, 16'h0008, 8, 16'h0000, 16'h0008};

    // Reset state and a fully silent first gamma cycle.
    release_reset();
    acc = output_spikes;
    for (int k = 0; k < GCW - 1; k++) begin
      tick();
      acc |= output_spikes;
    end
    check("first_gamma_silent", 32'(acc), 32'd0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      idle_until(vecs[i].offer_c);
      offer(vecs[i].values, vecs[i].en);
      idle_until(0);
      idle_until(vecs[i].probe_c);
`ifdef SPIKE_ENCODER_INVERT_EN
      check($sformatf("vec%0d_spikes", i), 32'(output_spikes), 32'(vecs[i].exp_inv));
`else
      check($sformatf("vec%0d_spikes", i), 32'(output_spikes), 32'(vecs[i].exp_def));
`endif
    end

    // Back-to-back offers at c=2: second waits until the cycle after the wrap.
    idle_until(0);
    idle_until(2);
    in_valid  = 1'b1;
    in_values = 48'(6) << 12;   // A: ch4 = 6
    in_enable = 16'h0010;
    tick();
    check("b2b_ready_dropped", 32'(in_ready), 32'd0);
    in_values = 48'(2) << 15;   // B: ch5 = 2
    in_enable = 16'h0020;
    low_cycles = 0;
    for (int k = 0; k < 40 && in_ready !== 1'b1; k++) begin
      low_cycles++;
      tick();
    end
    check("b2b_ready_low_cycles", 32'(low_cycles), 32'd13);
    check("b2b_ready_at_c", 32'(cur_c()), 32'd0);
    tick();
    in_valid = 1'b0;
    check("b2b_second_accepted", 32'(in_ready), 32'd0);
    idle_until(0);
    idle_until(5);
    check("b2b_second_fires", 32'(output_spikes), 32'h0020);

    // Offer exactly on the wrap edge with pending empty: ch2 = 0.
    idle_until(15);
    offer('0, 16'h0004);
`ifdef SPIKE_ENCODER_INVERT_EN
    check("wrap_bypass_c0", 32'(output_spikes), 32'h0000);
`else
    check("wrap_bypass_c0", 32'(output_spikes), 32'h0004);
`endif
    idle_until(7);
    check("wrap_bypass_c7", 32'(output_spikes), 32'h0004);
    idle_until(8);
`ifdef SPIKE_ENCODER_INVERT_EN
    check("wrap_bypass_c8", 32'(output_spikes), 32'h0004);
`else
    check("wrap_bypass_c8", 32'(output_spikes), 32'h0000);
`endif

    // No transfer during a gamma cycle: the next one is silent.
    idle_until(0);
    acc = output_spikes;
    for (int k = 0; k < GCW - 1; k++) begin
      tick();
      acc |= output_spikes;
    end
    check("silent_gamma", 32'(acc), 32'd0);

    // Reset at c=6 while ch0 (value 4) is pulsing.
    idle_until(2);
    offer(48'h4, 16'h0001);
    idle_until(0);
    idle_until(6);
    check("pre_reset_ch0", 32'(output_spikes), 32'h0001);
    #1;
    grst = 1'b1;
    #1;
    check("async_reset_spikes", 32'(output_spikes), 32'd0);
    check("async_reset_ready", 32'(in_ready), 32'd1);
    check("async_reset_gstart", 32'(gamma_start), 32'd1);
    release_reset();
    idle_until(3);
    offer('0, 16'h0001);
    idle_until(0);
`ifdef SPIKE_ENCODER_INVERT_EN
    check("post_reset_c0", 32'(output_spikes), 32'h0000);
`else
    check("post_reset_c0", 32'(output_spikes), 32'h0001);
`endif
    idle_until(7);
    check("post_reset_c7", 32'(output_spikes), 32'h0001);
    idle_until(14);
`ifdef SPIKE_ENCODER_INVERT_EN
    check("post_reset_c14", 32'(output_spikes), 32'h0001);
`else
    check("post_reset_c14", 32'(output_spikes), 32'h0000);
`endif

    // Randomized traffic; inputs change every cycle, including while held valid.
    for (int k = 0; k < 40 * GCW; k++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_values = 48'({$urandom(), $urandom()});
      in_enable = 16'($urandom());
      tick();
    end
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
